// File: rtl/adder_share_pkg.sv
// Shared types and constants for the shared-adder sequencer.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_NREQ       = 4;
    localparam int unsigned DEF_ADD_CYCLES = 2;
    localparam int unsigned CNT_W          = 4;

    // Ceiling log2; used to size requester IDs.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_arb.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr, searching cyclically.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt_c,
    output logic [IDW-1:0]  gnt_idx_c,
    output logic            any_c
);

    localparam int unsigned SW = IDW + 1;

    logic [SW-1:0]  pos;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        any_c     = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = SW'(rr_ptr) + SW'(k);
            if (pos >= SW'(NREQ)) pos = pos - SW'(NREQ);
            idx = IDW'(pos);
            if (en && !any_c && req[idx]) begin
                any_c        = 1'b1;
                gnt_idx_c    = idx;
                gnt_c[idx]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one 32-bit ripple-carry adder among NREQ requesters with round-robin grant.
// Optional subtract mode (req_sub port) is enabled by defining ADDER_SHARE_SUB_EN.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int unsigned NREQ       = DEF_NREQ,
    parameter int unsigned W          = 32,
    parameter int unsigned ADD_CYCLES = DEF_ADD_CYCLES,
    parameter int unsigned IDW        = clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ-1:0]     req_cin,
`ifdef ADDER_SHARE_SUB_EN
    input  logic [NREQ-1:0]     req_sub,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_sum,
    output logic                rsp_cout,
    output logic [IDW-1:0]      rsp_id
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic [IDW-1:0]   op_id_q, op_id_d;
`ifdef ADDER_SHARE_SUB_EN
    logic             op_sub_q, op_sub_d;
`endif
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [W-1:0]     a_arr [NREQ];
    logic [W-1:0]     b_arr [NREQ];
    logic             arb_en;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             hs;
    logic [W-1:0]     add_b;
    logic             add_cin;
    logic [W-1:0]     add_sum;
    logic             add_cout;
    logic             carry;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*W +: W];
        assign b_arr[i] = req_b[i*W +: W];
    end

    // Grants only when a result slot is free; held off entirely during reset.
    assign arb_en = !rst && ((state_q == IDLE) || ((state_q == DONE) && rsp_ready));

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .en        (arb_en),
        .gnt_c     (gnt),
        .gnt_idx_c (gnt_idx),
        .any_c     (hs)
    );

    assign req_ready = gnt;

    // Ripple-carry datapath fed only from the operand registers (multicycle path).
    always_comb begin
        add_b   = op_b_q;
        add_cin = op_cin_q;
`ifdef ADDER_SHARE_SUB_EN
        if (op_sub_q) begin
            add_b   = ~op_b_q;
            add_cin = 1'b1;
        end
`endif
        add_sum = '0;
        carry   = add_cin;
        for (int unsigned i = 0; i < W; i++) begin
            add_sum[i] = op_a_q[i] ^ add_b[i] ^ carry;
            carry      = (op_a_q[i] & add_b[i]) | (carry & (op_a_q[i] ^ add_b[i]));
        end
        add_cout = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hs) state_d = EVAL;
            EVAL:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (rsp_ready) state_d = hs ? EVAL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        op_id_d     = op_id_q;
`ifdef ADDER_SHARE_SUB_EN
        op_sub_d    = op_sub_q;
`endif
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;

        if (hs) begin
            op_a_d   = a_arr[gnt_idx];
            op_b_d   = b_arr[gnt_idx];
            op_cin_d = req_cin[gnt_idx];
            op_id_d  = gnt_idx;
`ifdef ADDER_SHARE_SUB_EN
            op_sub_d = req_sub[gnt_idx];
`endif
            cnt_d    = CNT_W'(ADD_CYCLES - 1);
            rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end

        unique case (state_q)
            EVAL: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_sum_d   = add_sum;
                    rsp_cout_d  = add_cout;
                    rsp_id_d    = op_id_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            op_id_q     <= '0;
`ifdef ADDER_SHARE_SUB_EN
            op_sub_q    <= 1'b0;
`endif
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            op_id_q     <= op_id_d;
`ifdef ADDER_SHARE_SUB_EN
            op_sub_q    <= op_sub_d;
`endif
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl (default parameters plus an ADD_CYCLES=1 instance).
`timescale 1ns/1ps
module tb_adder_share_ctrl;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned IDW  = 2;
    localparam int unsigned AC   = 2;

    typedef struct {
        logic [W-1:0]   sum;
        logic           cout;
        logic [IDW-1:0] id;
        int             t_exp;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready, req_cin, sub_v;
    logic [NREQ-1:0]   req_valid1, req_ready1;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              rsp_ready;
    logic              rsp_valid, rsp_cout, rsp_valid1, rsp_cout1;
    logic [W-1:0]      rsp_sum, rsp_sum1;
    logic [IDW-1:0]    rsp_id, rsp_id1;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    int   gnt_ids[$];
    int   gnt_cyc[$];
    bit   log_en  = 0;
    bit   rv_prev = 0;
    logic [W-1:0]   last_sum;
    logic           last_cout;
    logic [IDW-1:0] last_id;

    adder_share_ctrl #(.NREQ(NREQ), .W(W), .ADD_CYCLES(AC), .IDW(IDW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADDER_SHARE_SUB_EN
        .req_sub   (sub_v),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    adder_share_ctrl #(.NREQ(NREQ), .W(W), .ADD_CYCLES(1), .IDW(IDW)) u_dut_ac1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADDER_SHARE_SUB_EN
        .req_sub   (sub_v),
`endif
        .rsp_valid (rsp_valid1),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum1),
        .rsp_cout  (rsp_cout1),
        .rsp_id    (rsp_id1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W-1:0] nb;
        nb = ~b;
        if (sub) return {1'b0, a} + {1'b0, nb} + 33'd1;
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    // Monitor: pushes expectations on request handshakes, checks responses.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            rv_prev = 1'b0;
        end else begin
            if (rsp_valid && !rv_prev) begin
                chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) chk("latency", 64'(cyc), 64'(sb[0].t_exp));
            end
            if (rsp_valid && sb.size() > 0) begin
                chk("rsp_sum", 64'(rsp_sum), 64'(sb[0].sum));
                chk("rsp_cout", 64'(rsp_cout), 64'(sb[0].cout));
                chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                if (!rsp_ready) chk("bp_req_ready", 64'(req_ready), 64'd0);
                else begin
                    last_sum  = rsp_sum;
                    last_cout = rsp_cout;
                    last_id   = rsp_id;
                    void'(sb.pop_front());
                end
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    logic [W:0] r;
                    r       = model(req_a[i*W +: W], req_b[i*W +: W], req_cin[i], sub_v[i]);
                    e.sum   = r[W-1:0];
                    e.cout  = r[W];
                    e.id    = IDW'(i);
                    e.t_exp = cyc + int'(AC) + 1;
                    sb.push_back(e);
                    if (log_en) begin
                        gnt_ids.push_back(i);
                        gnt_cyc.push_back(cyc);
                    end
                end
            end
            chk("ready_onehot", 64'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0)), 64'd1);
            rv_prev = rsp_valid;
        end
    end

    task automatic wait_hs(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) ok = 1'b1;
        end
        chk("hs_done", 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) ok = 1'b1;
        end
        chk("drain", 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        sub_v[i]        = sub;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rel_cyc;
        int t0;
        bit ok;
        rst = 1'b1; req_valid = '0; req_valid1 = '0; req_cin = '0; sub_v = '0;
        req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // Reset state; requests presented during reset must not be accepted.
        repeat (3) @(posedge clk);
        #1 req_valid = 4'hF;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        @(posedge clk); #1 rst = 1'b0; req_valid = '0;

        // Reset while EVAL is in flight drops the operation.
        set_op(0, 32'd5, 32'd7, 1'b0, 1'b0);
        req_valid[0] = 1'b1;
        wait_hs(0);
        req_valid = '0; rst = 1'b1;
        @(negedge clk);
        chk("rst_eval_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rst_eval_valid", 64'(rsp_valid), 64'd0);
        end

        // All four requesting: round-robin order from rr_ptr=0.
        @(posedge clk); #1;
        for (int i = 0; i < int'(NREQ); i++) set_op(i, $urandom(), $urandom(), 1'($urandom()), 1'b0);
        log_en = 1'b1; rel_cyc = cyc; req_valid = 4'hF;
        for (int n = 0; n < 100 && gnt_ids.size() < 5; n++) begin
            @(posedge clk); #1;
        end
        req_valid = '0; log_en = 1'b0;
        chk("gnt_count", 64'(gnt_ids.size()), 64'd5);
        if (gnt_ids.size() >= 5) begin
            chk("idle_after_rst", 64'(gnt_cyc[0]), 64'(rel_cyc));
            for (int k = 0; k < 5; k++) chk("gnt_order", 64'(gnt_ids[k]), 64'(k % 4));
            for (int k = 1; k < 5; k++) chk("gnt_spacing", 64'(gnt_cyc[k] - gnt_cyc[k-1]), 64'(AC + 1));
        end
        drain();

        // Single op with full carry propagation out of bit 31.
        set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        req_valid[1] = 1'b1;
        wait_hs(1);
        req_valid = '0;
        drain();
        chk("tp1_sum", 64'(last_sum), 64'h0);
        chk("tp1_cout", 64'(last_cout), 64'd1);
        chk("tp1_id", 64'(last_id), 64'd1);

        // Backpressure: result held, no grants, then back-to-back grant on release.
        rsp_ready = 1'b0;
        set_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        set_op(3, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        req_valid[0] = 1'b1;
        wait_hs(0);
        req_valid = 4'b1000;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        chk("bp_rsp_seen", 64'(ok), 64'd1);
        chk("bp_sum", 64'(rsp_sum), 64'h1);
        chk("bp_cout", 64'(rsp_cout), 64'd1);
        repeat (10) @(posedge clk);
        #1 rsp_ready = 1'b1;
        #1 chk("b2b_grant", 64'(req_ready), 64'b1000);
        wait_hs(3);
        req_valid = '0;
        drain();

        // Carry-in ripple across 31 bits, ADD_CYCLES=2 and ADD_CYCLES=1.
        set_op(2, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
        req_valid[2] = 1'b1;
        wait_hs(2);
        req_valid = '0;
        drain();
        chk("cin_sum", 64'(last_sum), 64'h8000_0000);
        chk("cin_cout", 64'(last_cout), 64'd0);

        set_op(0, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
        req_valid1 = 4'b0001;
        ok = 1'b0; t0 = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_ready1[0]) begin ok = 1'b1; t0 = cyc; end
        end
        chk("ac1_hs", 64'(ok), 64'd1);
        @(posedge clk); #1 req_valid1 = '0;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid1) ok = 1'b1;
        end
        chk("ac1_rsp", 64'(ok), 64'd1);
        chk("ac1_lat", 64'(cyc), 64'(t0 + 2));
        chk("ac1_sum", 64'(rsp_sum1), 64'h8000_0000);
        chk("ac1_cout", 64'(rsp_cout1), 64'd0);
        chk("ac1_id", 64'(rsp_id1), 64'd0);
        @(posedge clk); #1;

`ifdef ADDER_SHARE_SUB_EN
        // Subtract mode: borrow shows as cout=0.
        set_op(2, 32'd3, 32'd5, 1'b0, 1'b1);
        req_valid[2] = 1'b1;
        wait_hs(2);
        req_valid = '0;
        drain();
        chk("sub1_sum", 64'(last_sum), 64'hFFFF_FFFE);
        chk("sub1_cout", 64'(last_cout), 64'd0);
        set_op(2, 32'd5, 32'd3, 1'b1, 1'b1);
        req_valid[2] = 1'b1;
        wait_hs(2);
        req_valid = '0;
        drain();
        chk("sub2_sum", 64'(last_sum), 64'h2);
        chk("sub2_cout", 64'(last_cout), 64'd1);
`endif

        // Random traffic with toggling valids and backpressure.
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom());
            for (int i = 0; i < int'(NREQ); i++) begin
`ifdef ADDER_SHARE_SUB_EN
                set_op(i, $urandom(), $urandom(), 1'($urandom()), 1'($urandom()));
`else
                set_op(i, $urandom(), $urandom(), 1'($urandom()), 1'b0);
`endif
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid = '0; rsp_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
